r_dispatcher_m: RTL and testbench

AXI4-Lite read-data (R) channel dispatcher for the interconnect. It takes the single R channel from one slave port and steers `rdata`/`rresp`/`rvalid` to exactly one of `NUM_MASTERS` master ports. The target is chosen by a one-hot master-select vector from the read arbiter. The handshake ready from the selected master is returned to the slave.

---
 rtl/r_dispatcher_m.sv | 120 ++++++++++++
 tb/tb_r_dispatcher_m.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/r_dispatcher_m.sv
// r_dispatcher_m: AXI4-Lite R channel dispatcher.
// Steers one slave-side read beat to the single master lane picked by a
// one-hot select vector, and returns that master's ready to the slave.
// Optional feature macro: R_DISPATCHER_OUTPUT_REG_EN
//   undefined -> purely combinational routing
//   defined   -> skid-buffer register slice ahead of the fan-out
module r_dispatcher_m #(
    parameter int DATA_WIDTH      = 32,
    parameter int TRANS_WR_RESP_W = 2,
    parameter int NUM_MASTERS     = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [DATA_WIDTH-1:0]                  s_axi_rdata_i,
    input  logic [TRANS_WR_RESP_W-1:0]             s_axi_rresp_i,
    input  logic                                   s_axi_rvalid_i,
    output logic                                   s_axi_rready_o,
    output logic [DATA_WIDTH*NUM_MASTERS-1:0]      m_axi_rdata_o,
    output logic [TRANS_WR_RESP_W*NUM_MASTERS-1:0] m_axi_rresp_o,
    output logic [NUM_MASTERS-1:0]                 m_axi_rvalid_o,
    input  logic [NUM_MASTERS-1:0]                 m_axi_rready_i,
    input  logic [NUM_MASTERS-1:0]                 Master_ID_Selected_i
);

    // A zero or multi-hot select never routes anywhere, so the beat waits.
    logic sel_legal;
    assign sel_legal = $onehot(Master_ID_Selected_i);

    // Common routing view consumed by the lane fan-out below.
    logic [NUM_MASTERS-1:0]     route_sel;
    logic                       route_valid;
    logic [DATA_WIDTH-1:0]      route_data;
    logic [TRANS_WR_RESP_W-1:0] route_resp;
    logic                       route_ready;

`ifdef R_DISPATCHER_OUTPUT_REG_EN
    logic                       out_valid_q;
    logic [DATA_WIDTH-1:0]      out_data_q;
    logic [TRANS_WR_RESP_W-1:0] out_resp_q;
    logic [NUM_MASTERS-1:0]     out_sel_q;
    logic                       skid_valid_q;
    logic [DATA_WIDTH-1:0]      skid_data_q;
    logic [TRANS_WR_RESP_W-1:0] skid_resp_q;
    logic [NUM_MASTERS-1:0]     skid_sel_q;
    logic                       slave_ready;
    logic                       accept;
    logic                       out_ready;

    // Ready comes straight from the skid flop; only a legal select may load.
    assign slave_ready = ~skid_valid_q & sel_legal;
    assign accept      = s_axi_rvalid_i & slave_ready;
    assign out_ready   = |(out_sel_q & m_axi_rready_i);

    // Output stage refills from the skid entry first, then from the slave;
    // a stalled output parks the incoming beat in the skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_resp_q   <= '0;
            out_sel_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_resp_q  <= '0;
            skid_sel_q   <= '0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                out_resp_q   <= skid_resp_q;
                out_sel_q    <= skid_sel_q;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= accept;
                if (accept) begin
                    out_data_q <= s_axi_rdata_i;
                    out_resp_q <= s_axi_rresp_i;
                    out_sel_q  <= Master_ID_Selected_i;
                end
            end
        end else if (accept) begin
            skid_valid_q <= 1'b1;
            skid_data_q  <= s_axi_rdata_i;
            skid_resp_q  <= s_axi_rresp_i;
            skid_sel_q   <= Master_ID_Selected_i;
        end
    end

    assign route_sel   = out_valid_q ? out_sel_q : '0;
    assign route_valid = out_valid_q;
    assign route_data  = out_data_q;
    assign route_resp  = out_resp_q;
    assign route_ready = slave_ready;
`else
    logic unused_clk;
    assign unused_clk = clk;

    assign route_sel   = sel_legal ? Master_ID_Selected_i : '0;
    assign route_valid = s_axi_rvalid_i;
    assign route_data  = s_axi_rdata_i;
    assign route_resp  = s_axi_rresp_i;
    assign route_ready = |(route_sel & m_axi_rready_i);
`endif

    // Fan out to the selected lane only; reset forces everything quiet.
    always_comb begin
        m_axi_rdata_o  = '0;
        m_axi_rresp_o  = '0;
        m_axi_rvalid_o = '0;
        s_axi_rready_o = rst_n & route_ready;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (rst_n && route_sel[k]) begin
                m_axi_rdata_o[k*DATA_WIDTH +: DATA_WIDTH]           = route_data;
                m_axi_rresp_o[k*TRANS_WR_RESP_W +: TRANS_WR_RESP_W] = route_resp;
                m_axi_rvalid_o[k]                                   = route_valid;
            end
        end
    end

endmodule

// File: tb/tb_r_dispatcher_m.sv
// tb_r_dispatcher_m: self-checking bench for the combinational build of
// r_dispatcher_m, directed cases followed by randomized traffic checked
// against a behavioural routing model.
module tb_r_dispatcher_m;

    localparam int DW = 32;
    localparam int RW = 2;
    localparam int NM = 16;

    logic              clk;
    logic              rst_n;
    logic [DW-1:0]     s_rdata;
    logic [RW-1:0]     s_rresp;
    logic              s_rvalid;
    logic              s_rready;
    logic [DW*NM-1:0]  m_rdata;
    logic [RW*NM-1:0]  m_rresp;
    logic [NM-1:0]     m_rvalid;
    logic [NM-1:0]     m_rready;
    logic [NM-1:0]     sel;

    int checks = 0;
    int errors = 0;

    logic [DW*NM-1:0] exp_rdata;
    logic [RW*NM-1:0] exp_rresp;
    logic [NM-1:0]    exp_rvalid;
    logic             exp_rready;

    r_dispatcher_m #(
        .DATA_WIDTH      (DW),
        .TRANS_WR_RESP_W (RW),
        .NUM_MASTERS     (NM)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .s_axi_rdata_i        (s_rdata),
        .s_axi_rresp_i        (s_rresp),
        .s_axi_rvalid_i       (s_rvalid),
        .s_axi_rready_o       (s_rready),
        .m_axi_rdata_o        (m_rdata),
        .m_axi_rresp_o        (m_rresp),
        .m_axi_rvalid_o       (m_rvalid),
        .m_axi_rready_i       (m_rready),
        .Master_ID_Selected_i (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [511:0] actual,
                               input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Reference: exactly one select bit routes the beat to that lane index.
    task automatic computeExpected();
        int cnt;
        int idx;
        cnt = 0;
        idx = 0;
        for (int i = 0; i < NM; i++) begin
            if (sel[i]) begin
                cnt++;
                idx = i;
            end
        end
        exp_rdata  = '0;
        exp_rresp  = '0;
        exp_rvalid = '0;
        exp_rready = 1'b0;
        if (rst_n === 1'b1 && cnt == 1) begin
            exp_rdata[idx*DW +: DW] = s_rdata;
            exp_rresp[idx*RW +: RW] = s_rresp;
            exp_rvalid[idx]         = s_rvalid;
            exp_rready              = m_rready[idx];
        end
    endtask

    task automatic compareAll(input string tag);
        computeExpected();
        checkOutput({tag, "_rdata"},  512'(m_rdata),  512'(exp_rdata));
        checkOutput({tag, "_rresp"},  512'(m_rresp),  512'(exp_rresp));
        checkOutput({tag, "_rvalid"}, 512'(m_rvalid), 512'(exp_rvalid));
        checkOutput({tag, "_rready"}, 512'(s_rready), 512'(exp_rready));
    endtask

    // Drive a full input set away from the rising edge, then sample.
    task automatic applyStimulus(input logic [NM-1:0] s, input logic [NM-1:0] r,
                                 input logic [DW-1:0] d, input logic [RW-1:0] rs,
                                 input logic v, input string tag);
        @(negedge clk);
        sel      = s;
        m_rready = r;
        s_rdata  = d;
        s_rresp  = rs;
        s_rvalid = v;
        #1;
        compareAll(tag);
    endtask

    initial begin
        logic [NM-1:0] rsel;
        rst_n    = 1'b0;
        sel      = 16'h0001;
        m_rready = 16'hFFFF;
        s_rdata  = 32'hCAFEF00D;
        s_rresp  = 2'b01;
        s_rvalid = 1'b1;
        #3;
        checkOutput("reset_rvalid", 512'(m_rvalid), 512'(16'h0000));
        checkOutput("reset_rready", 512'(s_rready), 512'(1'b0));
        checkOutput("reset_rdata",  512'(m_rdata),  512'(0));
        repeat (2) @(posedge clk);
        rst_n = 1'b1;

        applyStimulus(16'h0000, 16'hFFFF, 32'hDEADBEEF, 2'b00, 1'b1, "sel_zero");
        checkOutput("sel_zero_const", 512'({m_rvalid, s_rready}), 512'(0));
        applyStimulus(16'h0001, 16'h0001, 32'h12345678, 2'b01, 1'b1, "lane0");
        checkOutput("lane0_const", 512'(m_rdata[31:0]), 512'(32'h12345678));
        applyStimulus(16'h0020, 16'h0020, 32'hA5A5A5A5, 2'b10, 1'b1, "lane5");
        checkOutput("lane5_const", 512'(m_rdata[191:160]), 512'(32'hA5A5A5A5));
        applyStimulus(16'h8000, 16'h8000, 32'hFFFFFFFF, 2'b11, 1'b1, "lane15");
        checkOutput("lane15_const", 512'(m_rresp[31:30]), 512'(2'b11));
        applyStimulus(16'h0001, 16'hFFFF, 32'h0BADF00D, 2'b00, 1'b0, "novalid");
        applyStimulus(16'h0003, 16'hFFFF, 32'h0BADF00D, 2'b00, 1'b1, "multihot");
        applyStimulus(16'h0010, 16'hFFEF, 32'h11112222, 2'b01, 1'b1, "ignore_rdy");
        applyStimulus(16'h0004, 16'h0000, 32'h55AA55AA, 2'b01, 1'b1, "stall");
        checkOutput("stall_const", 512'({m_rvalid[2], s_rready}), 512'(2'b10));

        rst_n = 1'b0;
        #1;
        compareAll("midbeat_reset");
        checkOutput("midbeat_reset_const", 512'(m_rvalid), 512'(16'h0000));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compareAll("post_reset");

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       rsel = '0;
                3:       rsel = NM'($urandom);
                default: rsel = NM'(1) << $urandom_range(0, NM - 1);
            endcase
            applyStimulus(rsel, NM'($urandom), $urandom, RW'($urandom),
                          1'($urandom), "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
